// File: rtl/dma_copy_master.sv
// Word-granular DMA copy engine: copies CNT words from SRC to DST using alternating read/write beats.
// Build macro DMA_GUARD_EN blocks beats that would touch the protected secure-data or counter regions.
module dma_copy_master #(
  parameter logic [13:0] BASE_ADDR  = 14'h0090,
  parameter logic [15:0] SDATA_BASE = 16'h0400,
  parameter logic [15:0] SDATA_SIZE = 16'h0C00,
  parameter logic [15:0] CTR_BASE   = 16'h9000,
  parameter logic [15:0] CTR_SIZE   = 16'h001F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic [15:0] dma_addr,
  output logic        dma_en,
  output logic [1:0]  dma_we,
  output logic [15:0] dma_dout,
  input  logic [15:0] dma_din,
  input  logic        dma_ready,
  output logic        irq
);

`ifdef DMA_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state, state_next;
  logic [15:0] src, dst, cnt;
  logic        done, err;
  logic        set_done, set_err;

  logic [13:0] reg_off;
  logic        sel, reg_wr, busy, start_cmd;
  logic [15:0] src_inc, dst_inc, cnt_dec;
  logic        hit_src, hit_dst, hit_src_inc;

  // Region bounds are widened to 17 bits so a region ending at 16'hFFFF+1 still compares correctly.
  function automatic logic in_region(input logic [15:0] a, input logic [15:0] base,
                                     input logic [15:0] size);
    logic [16:0] top;
    top = {1'b0, base} + {1'b0, size};
    return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < top);
  endfunction

  function automatic logic is_protected(input logic [15:0] a);
    return GUARD_EN && (in_region(a, SDATA_BASE, SDATA_SIZE) || in_region(a, CTR_BASE, CTR_SIZE));
  endfunction

  assign reg_off     = per_addr - BASE_ADDR;
  assign sel         = (reg_off < 14'd4);
  assign reg_wr      = per_en && sel && (per_we != 2'b00);
  assign busy        = (state != IDLE);
  assign start_cmd   = reg_wr && (reg_off[1:0] == 2'd3) && per_din[0] && !busy;
  assign src_inc     = src + 16'd2;
  assign dst_inc     = dst + 16'd2;
  assign cnt_dec     = cnt - 16'd1;
  assign hit_src     = is_protected(src);
  assign hit_dst     = is_protected(dst);
  assign hit_src_inc = is_protected(src_inc);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_cmd && (cnt != 16'd0) && !hit_src) state_next = RD;
      RD:      if (dma_ready) state_next = hit_dst ? IDLE : WR;
      WR:      if (dma_ready) state_next = ((cnt_dec == 16'd0) || hit_src_inc) ? IDLE : RD;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dma_en   = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_cmd) begin
          if (cnt == 16'd0) set_done = 1'b1;
          else if (hit_src) set_err = 1'b1;
        end
      end
      RD: begin
        dma_en = 1'b1;
        if (dma_ready && hit_dst) set_err = 1'b1;
      end
      WR: begin
        dma_en = 1'b1;
        if (dma_ready) begin
          if (cnt_dec == 16'd0) set_done = 1'b1;
          else if (hit_src_inc) set_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus-side registers are loaded only on state transitions, so they hold steady through stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      src      <= '0;
      dst      <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      irq      <= 1'b0;
      dma_addr <= '0;
      dma_we   <= '0;
      dma_dout <= '0;
    end else begin
      irq <= set_done || set_err;
      if (reg_wr && !busy) begin
        case (reg_off[1:0])
          2'd0:    src <= {per_din[15:1], 1'b0};
          2'd1:    dst <= {per_din[15:1], 1'b0};
          2'd2:    cnt <= per_din;
          default: ;
        endcase
      end
      if (reg_wr && (reg_off[1:0] == 2'd3)) begin
        if (per_din[2]) done <= 1'b0;
        if (per_din[3]) err  <= 1'b0;
      end
      if (start_cmd) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (set_done) done <= 1'b1;
      if (set_err)  err  <= 1'b1;
      if ((state == RD) && dma_ready) dma_dout <= dma_din;
      if ((state == WR) && dma_ready) begin
        src <= src_inc;
        dst <= dst_inc;
        cnt <= cnt_dec;
      end
      if ((state == IDLE) && (state_next == RD)) begin
        dma_addr <= src;
        dma_we   <= 2'b00;
      end
      if ((state == RD) && (state_next == WR)) begin
        dma_addr <= dst;
        dma_we   <= 2'b11;
      end
      if ((state == WR) && (state_next == RD)) begin
        dma_addr <= src_inc;
        dma_we   <= 2'b00;
      end
      if (busy && (state_next == IDLE)) dma_we <= 2'b00;
    end
  end

  always_comb begin
    per_dout = '0;
    if (per_en && sel && (per_we == 2'b00)) begin
      case (reg_off[1:0])
        2'd0:    per_dout = src;
        2'd1:    per_dout = dst;
        2'd2:    per_dout = cnt;
        default: per_dout = {12'd0, err, done, busy, 1'b0};
      endcase
    end
  end

endmodule
